traffic_phase_scheduler: RTL
============================

Name: traffic_phase_scheduler

Overview:
Phase sequencer for a two-direction intersection (main road X, side road Y). It sequences green, blink, all-red and red phases from a shared timebase tick. X is held green until side-road demand arrives. It drives the Gx/Rx/Gy/Ry lamp outputs, a per-phase remaining-tick count for the countdown display, and a phase-entry strobe for the display logic.

Parameters:
TX_TICKS, 300, X green+blink duration in ticks (minimum, before demand hold)
TY_TICKS, 150, Y green+blink duration in ticks
BLINK_TICKS, 40, blink portion at the end of each green, in ticks; must be a multiple of 2*BLINK_HALF and < TX_TICKS, TY_TICKS
BLINK_HALF, 10, ticks per blink half-period
ALLRED_TICKS, 20, all-red clearance duration in ticks
CW, 12, width of the cnt/remain counter; must hold max(TX_TICKS, TY_TICKS)-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
tick  in  1  single-cycle timebase enable; all timing advances only on cycles with tick=1
req_y  in  1  side-road demand, level or pulse, sampled every cycle
emerg  in  1  emergency preempt request (used only with the optional feature)
Gx  out  1  X green lamp
Rx  out  1  X red lamp
Gy  out  1  Y green lamp
Ry  out  1  Y red lamp
phase  out  3  current state encoding
remain  out  CW  ticks remaining in the current phase (the cnt register)
phase_start  out  1  one-cycle pulse on the cycle after any state change

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- States (phase encoding): 0 X_GREEN, 1 X_BLINK, 2 RED_XY, 3 Y_GREEN, 4 Y_BLINK, 5 RED_YX. Encodings 6 and 7 go to RED_YX with cnt=ALLRED_TICKS-1.
- Reset values: state=RED_YX, cnt=ALLRED_TICKS-1, pend=0, phase_start=0. Lamps at reset: Rx=Ry=1, Gx=Gy=0.
- Lamp decode is combinational from registered state and the blink sub-count only; it has no input dependency.
  - X_GREEN: Gx=1, Ry=1.
  - X_BLINK: Gx=blink, Ry=1.
  - RED_XY and RED_YX: Rx=1, Ry=1.
  - Y_GREEN: Gy=1, Rx=1.
  - Y_BLINK: Gy=blink, Rx=1.
  - All lamps not listed for a state are 0.
- Blink: elapsed e=BLINK_TICKS-1-cnt. blink=1 when floor(e/BLINK_HALF) is odd, so the blink phase starts with the lamp off.
- Counter:
  - On a tick with cnt>0: cnt decrements.
  - On a tick with cnt==0: the transition is evaluated, and on the same edge cnt loads the new phase length minus 1.
  - With no tick, cnt holds.
- Phase lengths: X_GREEN is TX_TICKS-BLINK_TICKS, Y_GREEN is TY_TICKS-BLINK_TICKS, blink phases are BLINK_TICKS, all-red phases are ALLRED_TICKS.
- Transitions (only on tick with cnt==0):
  - X_GREEN goes to X_BLINK only if pend=1 or req_y=1. Otherwise it stays in X_GREEN with cnt held at 0 (demand hold).
  - X_BLINK goes to RED_XY.
  - RED_XY goes to Y_GREEN.
  - Y_GREEN goes to Y_BLINK.
  - Y_BLINK goes to RED_YX.
  - RED_YX goes to X_GREEN.
- Demand latch pend:
  - Set on any cycle with req_y=1.
  - Cleared on the edge entering Y_GREEN. If req_y=1 on that same edge, clear wins; demand raised during Y phases is re-latched afterwards.
- Latency: lamps change on the clk edge that samples tick=1 and cnt==0. phase_start=1 during the following cycle only.
- If tick and rst are asserted together, rst wins. Reset mid-phase returns immediately to the RED_YX reset state.
- A Gx and Gy combination that both lights green is never produced; the two are never 1 in the same cycle.

Optional Feature:
EMERG_PREEMPT_EN
- Defined:
  - emerg=1 during Y_GREEN forces Y_GREEN→Y_BLINK on the next tick, regardless of cnt, with cnt loaded to BLINK_TICKS-1.
  - emerg=1 in X_GREEN blocks the X_GREEN→X_BLINK transition even with demand pending.
  - emerg has no effect in any other state.
- Undefined: emerg is ignored, the port remains, and no logic depends on it.

Test Plan:
Bench parameters for scenarios 1–4: TX=20, TY=12, BLINK=4, HALF=1, ALLRED=2, tick=1 every cycle.
1. Reset release, req_y=0 → RED_YX for 2 cycles, then X_GREEN. remain counts 15..0 and holds at 0. Gx=1 and Ry=1 indefinitely; no X_BLINK.
2. From the hold in scenario 1, pulse req_y for 1 cycle → pend=1 → next cycle X_BLINK with Gx=0,1,0,1. Then RED_XY for 2 cycles, then Y_GREEN for 8 cycles with pend=0, then Y_BLINK for 4 cycles, then RED_YX. phase_start pulses at each entry.
3. tick only every 5th cycle → every dwell is 5× longer. State and cnt are frozen on non-tick cycles.
4. Assert rst in Y_GREEN with cnt=3 → next cycle phase=5, remain=1, Rx=Ry=1, Gy=0.
5. With EMERG_PREEMPT_EN: emerg=1 at Y_GREEN cnt=6 → next tick Y_BLINK with remain=3. In X_GREEN with pend=1, emerg held → no exit; on emerg release, X_BLINK on the next tick.
6. Without EMERG_PREEMPT_EN: repeat scenario 5 → sequence identical to scenario 2.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//
// Phase sequencer for a two-road intersection. X is the main road and Y is
// the side road. The cycle runs through these phases:
//   X_GREEN -> X_BLINK -> RED_XY -> Y_GREEN -> Y_BLINK -> RED_YX -> X_GREEN
// All timing advances only on cycles where the shared timebase 'tick' is 1.
// X stays green past its minimum dwell until side-road demand arrives.
//
// Optional feature: define EMERG_PREEMPT_EN to enable emergency preemption.
//   - emerg in Y_GREEN forces Y_BLINK on the next tick.
//   - emerg in X_GREEN blocks the X exit.
// When EMERG_PREEMPT_EN is undefined, the emerg input is ignored.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   tick        single-cycle timebase enable
//   req_y       side-road demand (level or pulse)
//   emerg       emergency preempt request
//   Gx, Rx      X green / red lamps
//   Gy, Ry      Y green / red lamps
//   phase       current state encoding
//   remain      ticks remaining in the current phase
//   phase_start one-cycle pulse on the cycle after a state change
module traffic_phase_scheduler #(
  parameter int TX_TICKS     = 300,
  parameter int TY_TICKS     = 150,
  parameter int BLINK_TICKS  = 40,
  parameter int BLINK_HALF   = 10,
  parameter int ALLRED_TICKS = 20,
  parameter int CW           = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          req_y,
  input  logic          emerg,
  output logic          Gx,
  output logic          Rx,
  output logic          Gy,
  output logic          Ry,
  output logic [2:0]    phase,
  output logic [CW-1:0] remain,
  output logic          phase_start
);

  typedef enum logic [2:0] {
    X_GREEN = 3'd0,
    X_BLINK = 3'd1,
    RED_XY  = 3'd2,
    Y_GREEN = 3'd3,
    Y_BLINK = 3'd4,
    RED_YX  = 3'd5
  } state_e;

  // Reload values: each is the phase length minus one.
  localparam logic [CW-1:0] X_GREEN_LAST = CW'(TX_TICKS - BLINK_TICKS - 1);
  localparam logic [CW-1:0] Y_GREEN_LAST = CW'(TY_TICKS - BLINK_TICKS - 1);
  localparam logic [CW-1:0] BLINK_LAST   = CW'(BLINK_TICKS - 1);
  localparam logic [CW-1:0] ALLRED_LAST  = CW'(ALLRED_TICKS - 1);
  localparam logic [CW-1:0] HALF_W       = CW'(BLINK_HALF);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          phase_start_q, phase_start_d;

  logic          emerg_force;
  logic          emerg_hold;
  logic          state_legal;
  logic [CW-1:0] elapsed;
  logic [CW-1:0] half_idx;
  logic          blink;

`ifdef EMERG_PREEMPT_EN
  assign emerg_force = emerg && (state_q == Y_GREEN);
  assign emerg_hold  = emerg && (state_q == X_GREEN);
`else
  logic unused_emerg;
  assign unused_emerg = emerg;
  assign emerg_force  = 1'b0;
  assign emerg_hold   = 1'b0;
`endif

  assign state_legal = (state_q <= RED_YX);

  // Next-state logic. On a tick, a non-zero count decrements. A zero count
  // evaluates the transition and reloads the count for the new phase.
  // X_GREEN with no demand keeps its count at 0, so it re-evaluates on
  // every later tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | req_y;
    if (!state_legal) begin
      state_d = RED_YX;
      cnt_d   = ALLRED_LAST;
    end else if (tick) begin
      if (emerg_force) begin
        state_d = Y_BLINK;
        cnt_d   = BLINK_LAST;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        case (state_q)
          X_GREEN: begin
            if ((pend_q || req_y) && !emerg_hold) begin
              state_d = X_BLINK;
              cnt_d   = BLINK_LAST;
            end
          end
          X_BLINK: begin
            state_d = RED_XY;
            cnt_d   = ALLRED_LAST;
          end
          RED_XY: begin
            state_d = Y_GREEN;
            cnt_d   = Y_GREEN_LAST;
          end
          Y_GREEN: begin
            state_d = Y_BLINK;
            cnt_d   = BLINK_LAST;
          end
          Y_BLINK: begin
            state_d = RED_YX;
            cnt_d   = ALLRED_LAST;
          end
          default: begin
            state_d = X_GREEN;
            cnt_d   = X_GREEN_LAST;
          end
        endcase
      end
    end
    // Entering Y_GREEN serves the demand. This clear overrides a
    // simultaneous req_y.
    if ((state_d == Y_GREEN) && (state_q != Y_GREEN)) begin
      pend_d = 1'b0;
    end
    phase_start_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RED_YX;
      cnt_q         <= ALLRED_LAST;
      pend_q        <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      phase_start_q <= phase_start_d;
    end
  end

  // The blink lamp starts off. It toggles every BLINK_HALF ticks of elapsed
  // blink time. The result is used only in blink states, where cnt_q is at
  // most BLINK_LAST.
  assign elapsed  = BLINK_LAST - cnt_q;
  assign half_idx = elapsed / HALF_W;
  assign blink    = half_idx[0];

  always_comb begin
    Gx = 1'b0;
    Rx = 1'b0;
    Gy = 1'b0;
    Ry = 1'b0;
    case (state_q)
      X_GREEN: begin Gx = 1'b1;  Ry = 1'b1; end
      X_BLINK: begin Gx = blink; Ry = 1'b1; end
      Y_GREEN: begin Gy = 1'b1;  Rx = 1'b1; end
      Y_BLINK: begin Gy = blink; Rx = 1'b1; end
      default: begin Rx = 1'b1;  Ry = 1'b1; end
    endcase
  end

  assign phase       = state_q;
  assign remain      = cnt_q;
  assign phase_start = phase_start_q;

endmodule
